// File: rtl/spi4_display_tx.sv
// Buffered 4-wire SPI transmitter (CS/SCK/SDO/DC) for SSD1306-class displays.
// Entries queue in a small FIFO; back-to-back words to the same select stream gaplessly.
module spi4_display_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned NUM_CS     = 1,
  parameter int unsigned CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_dc,
  input  logic [CS_W-1:0]   wr_cs,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_cpol,
  input  logic              cfg_lsb_first,
  output logic              sck,
  output logic              sdo,
  output logic              dc,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic              done,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int unsigned     PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned     BC_W     = $clog2(DATA_W);
  localparam logic [LVL_W-1:0] DEPTH_V  = LVL_W'(FIFO_DEPTH);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_W - 1);
  localparam logic [CS_W:0]    NUM_CS_V = (CS_W + 1)'(NUM_CS);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic              r_mem_dc   [FIFO_DEPTH];
  logic [CS_W-1:0]   r_mem_cs   [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_count;
  logic [LVL_W-1:0]  w_count_next;

  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_div_cnt;
  logic              r_cpol;
  logic              r_lsb;
  logic              r_phase;
  logic [DATA_W-1:0] r_shift;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [CS_W-1:0]   r_cur_cs;
  logic              r_sck;
  logic              r_sdo;
  logic              r_dc;
  logic [NUM_CS-1:0] r_cs_n;
  logic              r_busy;
  logic              r_done;

  logic              w_push;
  logic              w_empty;
  logic [CS_W-1:0]   w_cs_in;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_dc;
  logic [CS_W-1:0]   w_head_cs;
  logic              w_first_bit;
  logic [NUM_CS-1:0] w_cs_sel_n;
  logic              w_tick;
  logic              w_pop_idle;
  logic              w_lead;
  logic              w_trail;
  logic              w_last;
  logic              w_chain;
  logic              w_pop;
  logic              w_hold_end;

  assign w_empty     = (r_count == '0);
  assign w_push      = wr_valid && (r_count != DEPTH_V);
  assign w_cs_in     = ({1'b0, wr_cs} < NUM_CS_V) ? wr_cs : '0;
  assign w_head_data = r_mem_data[r_rd_ptr];
  assign w_head_dc   = r_mem_dc[r_rd_ptr];
  assign w_head_cs   = r_mem_cs[r_rd_ptr];
  assign w_first_bit = cfg_lsb_first ? w_head_data[0] : w_head_data[DATA_W-1];

  always_comb begin
    w_cs_sel_n = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (CS_W'(i) == w_head_cs) w_cs_sel_n[i] = 1'b0;
    end
  end

  // FIFO storage needs no reset; an empty count makes stale entries unreachable
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= wr_data;
      r_mem_dc[r_wr_ptr]   <= wr_dc;
      r_mem_cs[r_wr_ptr]   <= w_cs_in;
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + LVL_W'(1);
    else if (!w_push && w_pop) w_count_next = r_count - LVL_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_SETUP;
      S_SETUP: if (w_tick) w_next = S_SHIFT;
      S_SHIFT: if (w_last && !w_chain) w_next = S_HOLD;
      S_HOLD:  if (w_tick) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_phase marks SCK sitting at its active level, so the next tick is a trailing edge
  always_comb begin
    w_tick     = (r_state != S_IDLE) && (r_div_cnt == r_div);
    w_pop_idle = (r_state == S_IDLE) && !w_empty;
    w_lead     = ((r_state == S_SETUP) && w_tick) ||
                 ((r_state == S_SHIFT) && w_tick && !r_phase);
    w_trail    = (r_state == S_SHIFT) && w_tick && r_phase;
    w_last     = w_trail && (r_bit_cnt == LAST_BIT);
    w_chain    = w_last && !w_empty && (w_head_cs == r_cur_cs);
    w_pop      = w_pop_idle || w_chain;
    w_hold_end = (r_state == S_HOLD) && w_tick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div     <= '0;
      r_div_cnt <= '0;
      r_cpol    <= 1'b0;
      r_lsb     <= 1'b0;
      r_phase   <= 1'b0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_cur_cs  <= '0;
      r_sck     <= 1'b0;
      r_sdo     <= 1'b0;
      r_dc      <= 1'b0;
      r_cs_n    <= '1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_last;
      r_busy <= (w_next != S_IDLE) || (w_count_next != '0);

      if (w_pop || w_tick || (r_state == S_IDLE)) r_div_cnt <= '0;
      else                                        r_div_cnt <= r_div_cnt + DIV_W'(1);

      if (w_pop) begin
        r_div     <= cfg_div;
        r_cpol    <= cfg_cpol;
        r_lsb     <= cfg_lsb_first;
        r_shift   <= w_head_data;
        r_dc      <= w_head_dc;
        r_sdo     <= w_first_bit;
        r_cur_cs  <= w_head_cs;
        r_bit_cnt <= '0;
      end else if (w_trail && !w_last) begin
        r_shift   <= r_lsb ? (r_shift >> 1) : (r_shift << 1);
        r_sdo     <= r_lsb ? r_shift[1] : r_shift[DATA_W-2];
        r_bit_cnt <= r_bit_cnt + BC_W'(1);
      end else if ((r_state == S_SETUP) && w_tick) begin
        r_bit_cnt <= '0;
      end

      if (w_pop_idle)      r_cs_n <= w_cs_sel_n;
      else if (w_hold_end) r_cs_n <= '1;

      if (r_state == S_IDLE) begin
        r_sck   <= cfg_cpol;
        r_phase <= 1'b0;
      end else if (w_lead) begin
        r_sck   <= ~r_cpol;
        r_phase <= 1'b1;
      end else if (w_trail) begin
        r_sck   <= r_cpol;
        r_phase <= 1'b0;
      end
    end
  end

  assign wr_ready   = (r_count != DEPTH_V);
  assign fifo_level = r_count;
  assign sck        = r_sck;
  assign sdo        = r_sdo;
  assign dc         = r_dc;
  assign cs_n       = r_cs_n;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_spi4_display_tx.sv
// Directed bench for spi4_display_tx with a timeline-based reference model
// and a bus sniffer that decodes the words a display would receive.
module tb_spi4_display_tx;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = '0;
  logic       wr_dc = 1'b0;
  logic [0:0] wr_cs = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_cpol = 1'b0;
  logic       cfg_lsb_first = 1'b0;
  logic       sck, sdo, dc, busy, done;
  logic [1:0] cs_n;
  logic [2:0] fifo_level;

  spi4_display_tx #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(8), .NUM_CS(2)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_dc(wr_dc), .wr_cs(wr_cs), .cfg_div(cfg_div),
    .cfg_cpol(cfg_cpol), .cfg_lsb_first(cfg_lsb_first), .sck(sck), .sdo(sdo),
    .dc(dc), .cs_n(cs_n), .busy(busy), .done(done), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each word is a timeline of 2*8 SCK toggles spaced one
  // half-period (div+1) apart from its pop; a frame ends one half-period after the last toggle.
  typedef struct packed { logic cs; logic dc; logic [7:0] data; } ent_t;
  ent_t q[$];
  ent_t cur;
  bit   act, ending, cpol_l, lsb_l;
  int   t, h;
  logic m_sck, m_sdo, m_dc, m_done, m_busy;
  logic [1:0] m_cs_n;

  function automatic logic bit_of(input ent_t e, input bit lsb, input int i);
    return lsb ? e.data[i] : e.data[7-i];
  endfunction

  task start_word();
    cur    = q.pop_front();
    h      = int'(cfg_div) + 1;
    cpol_l = cfg_cpol;
    lsb_l  = cfg_lsb_first;
    t      = 0;
    ending = 0;
    act    = 1;
    m_dc   = cur.dc;
    m_sdo  = bit_of(cur, lsb_l, 0);
    m_cs_n = 2'b11;
    m_cs_n[cur.cs] = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      act = 0; ending = 0; t = 0;
      m_sck = 0; m_sdo = 0; m_dc = 0; m_done = 0; m_busy = 0; m_cs_n = 2'b11;
    end else begin : mdl
      bit   push;
      ent_t e;
      int   tog;
      push = wr_valid && (q.size() < DEPTH);
      e = '{cs: wr_cs, dc: wr_dc, data: wr_data};
      m_done = 0;
      if (!act) begin
        m_sck = cfg_cpol;
        if (q.size() > 0) start_word();
      end else begin
        t++;
        if (!ending) begin
          if (t % h == 0) begin
            tog   = t / h;
            m_sck = cpol_l ^ tog[0];
            m_sdo = bit_of(cur, lsb_l, (tog / 2 > 7) ? 7 : tog / 2);
          end
          if (t == 16 * h) begin
            m_done = 1;
            if (q.size() > 0 && q[0].cs == cur.cs) start_word();
            else ending = 1;
          end
        end else if (t == 17 * h) begin
          act    = 0;
          m_cs_n = 2'b11;
        end
      end
      if (push) q.push_back(e);
      m_busy = act || (q.size() > 0);
    end
  end

  bit   chk_en = 0;
  logic prev_sck = 1'b0;
  logic [7:0] sh = '0;
  int   nbits = 0, lead0 = 0, lead1 = 0, run0 = 0, run1 = 0, last0 = 0, last1 = 0;
  int   gap = 0, gb0 = 0, gb1 = 0, done_cnt = 0;
  ent_t log_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sck", sck, m_sck);
      chk("sdo", sdo, m_sdo);
      chk("dc", dc, m_dc);
      chk("cs_n", cs_n, m_cs_n);
      chk("done", done, m_done);
      chk("busy", busy, m_busy);
      chk("fifo_level", fifo_level, 32'(q.size()));
      chk("wr_ready", wr_ready, q.size() != DEPTH);
      chk("cs_exclusive", cs_n != 2'b00, 1);
    end
    if (!cs_n[0] && run0 == 0) begin gb0 = gap; lead0 = 0; end
    if (!cs_n[1] && run1 == 0) begin gb1 = gap; lead1 = 0; end
    if (cs_n == 2'b11) gap++; else gap = 0;
    if (!cs_n[0]) run0++; else if (run0 > 0) begin last0 = run0; run0 = 0; end
    if (!cs_n[1]) run1++; else if (run1 > 0) begin last1 = run1; run1 = 0; end
    if (done) done_cnt++;
    if (rst || cs_n == 2'b11) nbits = 0;
    else if (prev_sck == cfg_cpol && sck != cfg_cpol) begin
      sh = {sh[6:0], sdo};
      nbits++;
      if (!cs_n[0]) lead0++;
      if (!cs_n[1]) lead1++;
      if (nbits == 8) begin
        log_q.push_back('{cs: cs_n[0], dc: dc, data: sh});
        nbits = 0;
      end
    end
    prev_sck = sck;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic c, input logic d, input logic [7:0] v);
    wr_valid = 1'b1; wr_cs = c; wr_dc = d; wr_data = v;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    int i;
    for (i = 0; i < maxc && (busy || cs_n != 2'b11); i++) step();
    chk({nm, "_timeout"}, i < maxc, 1);
  endtask

  task automatic chk_log(input string nm, input int base, input logic [9:0] exp [$]);
    chk({nm, "_log_count"}, log_q.size() - base, exp.size());
    for (int k = 0; k < exp.size() && base + k < log_q.size(); k++)
      chk({nm, "_log_word"}, log_q[base + k], exp[k]);
  endtask

  initial begin
    int lc, dcnt, i;
    logic [9:0] e [$];

    repeat (3) step();
    chk("rst_cs_n", cs_n, 2'b11);
    chk("rst_sck", sck, 0);
    chk("rst_sdo", sdo, 0);
    chk("rst_dc", dc, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_wr_ready", wr_ready, 1);
    rst = 1'b0;
    chk_en = 1;
    repeat (2) step();

    // Single command word 0xAE, div 0, mode 0, MSB first
    lc = log_q.size(); dcnt = done_cnt;
    push(1'b0, 1'b0, 8'hAE);
    chk("t1_cs_before_pop", cs_n, 2'b11);
    step();
    chk("t1_cs_after_pop", cs_n, 2'b10);
    chk("t1_first_bit", sdo, 1);
    wait_idle("t1", 100);
    chk("t1_cs_low_cycles", last0, 17);
    chk("t1_done_pulses", done_cnt - dcnt, 1);
    e = '{10'h0AE};
    chk_log("t1", lc, e);

    // cs1 word in flight while four cs0 data words fill the FIFO; fifth is dropped
    cfg_div = 8'd3;
    lc = log_q.size();
    push(1'b1, 1'b0, 8'h3C);
    push(1'b0, 1'b1, 8'h01);
    push(1'b0, 1'b1, 8'h02);
    push(1'b0, 1'b1, 8'h04);
    push(1'b0, 1'b1, 8'h08);
    chk("t2_level_full", fifo_level, 4);
    chk("t2_ready_full", wr_ready, 0);
    push(1'b0, 1'b1, 8'h10);
    chk("t2_level_after_drop", fifo_level, 4);
    wait_idle("t2", 1000);
    chk("t2_cs1_len", last1, 68);
    chk("t2_cs0_len", last0, 260);
    chk("t2_gap", gb0, 1);
    chk("t2_sck_periods", lead0, 32);
    e = '{10'h23C, 10'h101, 10'h102, 10'h104, 10'h108};
    chk_log("t2", lc, e);

    // Back-to-back frames to different selects
    cfg_div = 8'd0;
    lc = log_q.size();
    push(1'b0, 1'b0, 8'h55);
    push(1'b1, 1'b1, 8'hAA);
    wait_idle("t3", 200);
    chk("t3_gap", gb1, 1);
    chk("t3_cs0_len", last0, 17);
    chk("t3_cs1_len", last1, 17);
    e = '{10'h055, 10'h3AA};
    chk_log("t3", lc, e);

    // CPOL 1, LSB first
    cfg_cpol = 1'b1; cfg_lsb_first = 1'b1;
    repeat (2) step();
    chk("t4_idle_high", sck, 1);
    lc = log_q.size();
    push(1'b0, 1'b1, 8'h80);
    wait_idle("t4", 100);
    chk("t4_idle_high_after", sck, 1);
    e = '{10'h101};
    chk_log("t4", lc, e);
    cfg_cpol = 1'b0; cfg_lsb_first = 1'b0;
    repeat (2) step();

    // Asynchronous reset after the third leading edge, one entry still queued
    cfg_div = 8'd1;
    lc = log_q.size();
    push(1'b0, 1'b0, 8'hF0);
    push(1'b0, 1'b0, 8'h0F);
    for (i = 0; i < 200 && !(lead0 == 3 && !cs_n[0]); i++) step();
    chk("t5_timeout", i < 200, 1);
    rst = 1'b1;
    #1;
    chk("t5_cs_n", cs_n, 2'b11);
    chk("t5_sck", sck, 0);
    chk("t5_level", fifo_level, 0);
    chk("t5_wr_ready", wr_ready, 1);
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    chk("t5_busy_after", busy, 0);
    chk("t5_cs_after", cs_n, 2'b11);
    chk("t5_no_partial", log_q.size(), lc);

    // Divider change mid-word affects only the following word
    cfg_div = 8'd1;
    lc = log_q.size();
    push(1'b0, 1'b1, 8'hC3);
    push(1'b0, 1'b1, 8'h5A);
    repeat (6) step();
    cfg_div = 8'd7;
    wait_idle("t6", 1000);
    chk("t6_frame_len", last0, 168);
    e = '{10'h1C3, 10'h15A};
    chk_log("t6", lc, e);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
